// File: rtl/fpu_chk_pkg.sv
// Shared types, constants and IEEE-754 single-precision classifiers for the FPU result checker.
package fpu_chk_pkg;

  localparam int unsigned F32_W = 32;

  localparam logic [F32_W-1:0] F32_QNAN = 32'h7FC0_0000;
  localparam logic [F32_W-1:0] F32_PINF = 32'h7F80_0000;
  localparam logic [F32_W-1:0] KEY_BIAS = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  typedef struct packed {
    logic [F32_W-1:0] a;
    logic [F32_W-1:0] b;
    logic [F32_W-1:0] o;
    logic [F32_W-1:0] g;
  } chk_vec_t;

  function automatic logic is_nan(input logic [F32_W-1:0] x);
    return ((x & F32_PINF) == F32_PINF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [F32_W-1:0] x);
    return x[30:0] == F32_PINF[30:0];
  endfunction

  function automatic logic is_zero(input logic [F32_W-1:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // Sign-magnitude to monotonic unsigned key, so adjacent floats differ by one.
  function automatic logic [F32_W-1:0] f32_key(input logic [F32_W-1:0] x);
    return x[31] ? (KEY_BIAS - {1'b0, x[30:0]}) : (KEY_BIAS + {1'b0, x[30:0]});
  endfunction

endpackage

// File: rtl/fpu_result_checker_if.sv
// Vector-in / result-out bundle between the FPU harness (master) and the result checker (slave).
interface fpu_result_checker_if #(
  parameter int unsigned CNT_W = 32
);

  localparam int unsigned DATA_W = 32;

  logic              CLR;
  logic              VALID;
  logic              LAST;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] O;
  logic [DATA_W-1:0] GOLDEN;

  logic              MISMATCH;
  logic              DONE;
  logic [CNT_W-1:0]  PASS_CNT;
  logic [CNT_W-1:0]  FAIL_CNT;
  logic [DATA_W-1:0] MAX_ULP;
  logic              FAIL_VALID;
  logic [CNT_W-1:0]  FAIL_IDX;
  logic [DATA_W-1:0] FAIL_A;
  logic [DATA_W-1:0] FAIL_B;
  logic [DATA_W-1:0] FAIL_O;
  logic [DATA_W-1:0] FAIL_GOLDEN;
  logic              OVERRUN;

  modport master (
    output CLR, VALID, LAST, A, B, O, GOLDEN,
    input  MISMATCH, DONE, PASS_CNT, FAIL_CNT, MAX_ULP, FAIL_VALID, FAIL_IDX,
    input  FAIL_A, FAIL_B, FAIL_O, FAIL_GOLDEN, OVERRUN
  );

  modport slave (
    input  CLR, VALID, LAST, A, B, O, GOLDEN,
    output MISMATCH, DONE, PASS_CNT, FAIL_CNT, MAX_ULP, FAIL_VALID, FAIL_IDX,
    output FAIL_A, FAIL_B, FAIL_O, FAIL_GOLDEN, OVERRUN
  );

endinterface

// File: rtl/fpu_ulp_compare.sv
// Combinational pass/fail classification of one unit output against its golden value.
module fpu_ulp_compare
  import fpu_chk_pkg::*;
#(
  parameter int unsigned ULP_TOL    = 0,
  parameter bit          ZERO_EQUIV = 1'b1,
  parameter bit          NAN_EQUIV  = 1'b1,
  parameter bit          INT_MODE   = 1'b0
) (
  input  logic [F32_W-1:0] i_o,
  input  logic [F32_W-1:0] i_g,
  output logic             o_pass_c,
  output logic [F32_W-1:0] o_diff_c,
  output logic             o_ulp_valid_c
);

  logic [F32_W-1:0] w_key_o;
  logic [F32_W-1:0] w_key_g;
  logic             w_eq;

  // Rules are evaluated in priority order; only the last one is a tolerance compare.
  always_comb begin
    o_pass_c      = 1'b0;
    o_ulp_valid_c = 1'b0;
    w_key_o       = f32_key(i_o);
    w_key_g       = f32_key(i_g);
    w_eq          = (i_o == i_g);
    o_diff_c      = (w_key_o >= w_key_g) ? (w_key_o - w_key_g) : (w_key_g - w_key_o);

    if (INT_MODE) begin
      o_pass_c = w_eq;
    end else if (is_nan(i_o) || is_nan(i_g)) begin
      o_pass_c = is_nan(i_o) && is_nan(i_g) && (NAN_EQUIV || w_eq);
    end else if (is_inf(i_o) || is_inf(i_g)) begin
      o_pass_c = w_eq;
    end else if (!ZERO_EQUIV && (is_zero(i_o) || is_zero(i_g))) begin
      o_pass_c = w_eq;
    end else begin
      o_ulp_valid_c = 1'b1;
      o_pass_c      = (o_diff_c <= F32_W'(ULP_TOL));
    end
  end

endmodule

// File: rtl/fpu_result_checker.sv
// Two-stage scoreboard for the FPU harness: classifies each vector, keeps counters,
// worst ULP error and first-fail capture, and signals DONE once the run has drained.
module fpu_result_checker
  import fpu_chk_pkg::*;
#(
  parameter int unsigned ULP_TOL    = 0,
  parameter bit          ZERO_EQUIV = 1'b1,
  parameter bit          NAN_EQUIV  = 1'b1,
  parameter int unsigned CNT_W      = 32,
  parameter bit          INT_MODE   = 1'b0
) (
  input logic                 MCLK,
  input logic                 nRST,
  fpu_result_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t       r_state;
  chk_state_t       w_state_next;
  logic             w_accept;
  logic             w_overrun_set;

  logic [CNT_W-1:0] r_idx;

  logic             r_s1_valid;
  chk_vec_t         r_s1_vec;
  logic [CNT_W-1:0] r_s1_idx;

  logic             w_pass;
  logic             w_ulp_valid;
  logic [F32_W-1:0] w_diff;

  logic             r_s2_valid;
  chk_vec_t         r_s2_vec;
  logic [CNT_W-1:0] r_s2_idx;
  logic             r_s2_pass;
  logic             r_s2_ulp_valid;
  logic [F32_W-1:0] r_s2_diff;

  logic             r_mismatch;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [F32_W-1:0] r_max_ulp;
  logic             r_fail_valid;
  logic [CNT_W-1:0] r_fail_idx;
  chk_vec_t         r_fail_vec;
  logic             r_overrun;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Run control; DRAIN completes when nothing is left in S1, so S2 empties on the same edge.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_overrun_set = 1'b0;
    if (bus.CLR) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.VALID) begin
            w_accept     = 1'b1;
            w_state_next = bus.LAST ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (bus.VALID) begin
            w_accept = 1'b1;
            if (bus.LAST) begin
              w_state_next = DRAIN;
            end
          end
        end
        DRAIN: begin
          w_overrun_set = bus.VALID;
          if (!r_s1_valid) begin
            w_state_next = DONE;
          end
        end
        DONE: begin
          w_overrun_set = bus.VALID;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (bus.CLR) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      if (w_accept) begin
        r_idx <= sat_inc(r_idx);
      end
    end
  end

  fpu_ulp_compare #(
    .ULP_TOL    (ULP_TOL),
    .ZERO_EQUIV (ZERO_EQUIV),
    .NAN_EQUIV  (NAN_EQUIV),
    .INT_MODE   (INT_MODE)
  ) u_cmp (
    .i_o           (r_s1_vec.o),
    .i_g           (r_s1_vec.g),
    .o_pass_c      (w_pass),
    .o_diff_c      (w_diff),
    .o_ulp_valid_c (w_ulp_valid)
  );

  // Pipeline payload; qualified by the valid bits above.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_s1_vec       <= '0;
      r_s1_idx       <= '0;
      r_s2_vec       <= '0;
      r_s2_idx       <= '0;
      r_s2_pass      <= 1'b0;
      r_s2_ulp_valid <= 1'b0;
      r_s2_diff      <= '0;
    end else begin
      if (w_accept) begin
        r_s1_vec <= '{a: bus.A, b: bus.B, o: bus.O, g: bus.GOLDEN};
        r_s1_idx <= r_idx;
      end
      r_s2_vec       <= r_s1_vec;
      r_s2_idx       <= r_s1_idx;
      r_s2_pass      <= w_pass;
      r_s2_ulp_valid <= w_ulp_valid;
      r_s2_diff      <= w_diff;
    end
  end

  // Commit stage: counters, worst ULP, first-fail capture and sticky overrun.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_mismatch   <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_max_ulp    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_vec   <= '0;
      r_overrun    <= 1'b0;
    end else if (bus.CLR) begin
      r_mismatch   <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_max_ulp    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_vec   <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
      if (r_s2_valid) begin
        if (r_s2_pass) begin
          r_pass_cnt <= sat_inc(r_pass_cnt);
        end else begin
          r_fail_cnt <= sat_inc(r_fail_cnt);
          r_mismatch <= 1'b1;
          if (!r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_idx   <= r_s2_idx;
            r_fail_vec   <= r_s2_vec;
          end
        end
        if (r_s2_ulp_valid && (r_s2_diff > r_max_ulp)) begin
          r_max_ulp <= r_s2_diff;
        end
      end
    end
  end

  assign bus.MISMATCH    = r_mismatch;
  assign bus.DONE        = (r_state == DONE);
  assign bus.PASS_CNT    = r_pass_cnt;
  assign bus.FAIL_CNT    = r_fail_cnt;
  assign bus.MAX_ULP     = r_max_ulp;
  assign bus.FAIL_VALID  = r_fail_valid;
  assign bus.FAIL_IDX    = r_fail_idx;
  assign bus.FAIL_A      = r_fail_vec.a;
  assign bus.FAIL_B      = r_fail_vec.b;
  assign bus.FAIL_O      = r_fail_vec.o;
  assign bus.FAIL_GOLDEN = r_fail_vec.g;
  assign bus.OVERRUN     = r_overrun;

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench: three checker configurations share one stimulus stream.
module tb_fpu_result_checker;

  logic        MCLK = 1'b0;
  logic        nRST;
  logic        clr;
  logic        valid;
  logic        last;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] o;
  logic [31:0] g;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 MCLK = ~MCLK;

  // A: defaults; B: ULP_TOL=1, strict zeros/NaNs, 4-bit counters; C: integer mode.
  fpu_result_checker_if #(.CNT_W(32)) if_a ();
  fpu_result_checker_if #(.CNT_W(4))  if_b ();
  fpu_result_checker_if #(.CNT_W(32)) if_c ();

  assign if_a.CLR = clr;   assign if_a.VALID = valid; assign if_a.LAST = last;
  assign if_a.A = a;       assign if_a.B = b;         assign if_a.O = o;   assign if_a.GOLDEN = g;
  assign if_b.CLR = clr;   assign if_b.VALID = valid; assign if_b.LAST = last;
  assign if_b.A = a;       assign if_b.B = b;         assign if_b.O = o;   assign if_b.GOLDEN = g;
  assign if_c.CLR = clr;   assign if_c.VALID = valid; assign if_c.LAST = last;
  assign if_c.A = a;       assign if_c.B = b;         assign if_c.O = o;   assign if_c.GOLDEN = g;

  fpu_result_checker u_a (.MCLK(MCLK), .nRST(nRST), .bus(if_a));

  fpu_result_checker #(
    .ULP_TOL(1), .ZERO_EQUIV(1'b0), .NAN_EQUIV(1'b0), .CNT_W(4), .INT_MODE(1'b0)
  ) u_b (.MCLK(MCLK), .nRST(nRST), .bus(if_b));

  fpu_result_checker #(
    .ULP_TOL(0), .ZERO_EQUIV(1'b1), .NAN_EQUIV(1'b1), .CNT_W(32), .INT_MODE(1'b1)
  ) u_c (.MCLK(MCLK), .nRST(nRST), .bus(if_c));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] vo, input logic [31:0] vg, input logic vl);
    valid = 1'b1; a = va; b = vb; o = vo; g = vg; last = vl;
    tick();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; clr = 1'b0; valid = 1'b0; last = 1'b0;
    a = '0; b = '0; o = '0; g = '0;
    tick(2);
    chk("rst_a_pass",   32'(if_a.PASS_CNT),   32'd0);
    chk("rst_b_fail",   32'(if_b.FAIL_CNT),   32'd0);
    chk("rst_a_done",   32'(if_a.DONE),       32'd0);
    chk("rst_a_fvalid", 32'(if_a.FAIL_VALID), 32'd0);
    nRST = 1'b1;
    tick();

    // Equality and one-ULP tolerance, back-to-back
    send(32'h1, 32'h2, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    send(32'h3, 32'h4, 32'h3F80_0001, 32'h3F80_0000, 1'b0);
    tick();
    chk("t1_a_pass",      32'(if_a.PASS_CNT), 32'd1);
    chk("t1_a_fail_t+1",  32'(if_a.FAIL_CNT), 32'd0);
    chk("t1_a_mm_t+1",    32'(if_a.MISMATCH), 32'd0);
    tick();
    chk("t1_a_fail",      32'(if_a.FAIL_CNT), 32'd1);
    chk("t1_a_mm_t+2",    32'(if_a.MISMATCH), 32'd1);
    chk("t1_a_maxulp",    if_a.MAX_ULP,       32'd1);
    chk("t1_b_pass",      32'(if_b.PASS_CNT), 32'd2);
    chk("t1_b_maxulp",    if_b.MAX_ULP,       32'd1);
    chk("t1_c_fail",      32'(if_c.FAIL_CNT), 32'd1);
    chk("t1_c_maxulp",    if_c.MAX_ULP,       32'd0);
    tick();
    chk("t1_a_mm_pulse",  32'(if_a.MISMATCH), 32'd0);
    clear();
    chk("clr_a_pass",     32'(if_a.PASS_CNT),   32'd0);
    chk("clr_a_maxulp",   if_a.MAX_ULP,         32'd0);
    chk("clr_a_fvalid",   32'(if_a.FAIL_VALID), 32'd0);

    // Special values
    send(32'h10, 32'h20, fpu_chk_pkg::F32_QNAN, 32'h7FC0_0001, 1'b0);
    send(32'h11, 32'h21, 32'h0000_0000, 32'h8000_0000, 1'b0);
    send(32'h12, 32'h22, 32'h7F80_0000, 32'h7F7F_FFFF, 1'b0);
    send(32'h13, 32'h23, 32'hBF80_0000, 32'h3F80_0000, 1'b0);
    send(32'h14, 32'h24, 32'h3F80_0002, 32'h3F80_0000, 1'b0);
    tick(2);
    chk("t2_a_pass",   32'(if_a.PASS_CNT), 32'd2);
    chk("t2_a_fail",   32'(if_a.FAIL_CNT), 32'd3);
    chk("t2_a_maxulp", if_a.MAX_ULP,       32'h7F00_0000);
    chk("t2_a_fidx",   32'(if_a.FAIL_IDX), 32'd2);
    chk("t2_a_fo",     if_a.FAIL_O,        32'h7F80_0000);
    chk("t2_b_pass",   32'(if_b.PASS_CNT), 32'd0);
    chk("t2_b_fail",   32'(if_b.FAIL_CNT), 32'd5);
    chk("t2_b_maxulp", if_b.MAX_ULP,       32'h7F00_0000);
    chk("t2_b_fidx",   32'(if_b.FAIL_IDX), 32'd0);
    chk("t2_b_fo",     if_b.FAIL_O,        32'h7FC0_0000);
    chk("t2_c_fail",   32'(if_c.FAIL_CNT), 32'd5);
    chk("t2_c_maxulp", if_c.MAX_ULP,       32'd0);
    clear();

    // First-fail capture holds over a later fail
    send(32'hA0, 32'hB0, 32'h4000_0000, 32'h4000_0000, 1'b0);
    send(32'hA1, 32'hB1, 32'hC049_0FDB, 32'hC049_0FDB, 1'b0);
    send(32'h1111_1111, 32'h2222_2222, 32'h4040_0001, 32'h4040_0000, 1'b0);
    send(32'hA3, 32'hB3, 32'h0000_0000, 32'h0000_0000, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    tick(2);
    chk("t3_a_fvalid", 32'(if_a.FAIL_VALID), 32'd1);
    chk("t3_a_fidx",   32'(if_a.FAIL_IDX),   32'd2);
    chk("t3_a_fa",     if_a.FAIL_A,          32'h1111_1111);
    chk("t3_a_fb",     if_a.FAIL_B,          32'h2222_2222);
    chk("t3_a_fo",     if_a.FAIL_O,          32'h4040_0001);
    chk("t3_a_fg",     if_a.FAIL_GOLDEN,     32'h4040_0000);
    chk("t3_a_fail",   32'(if_a.FAIL_CNT),   32'd2);
    chk("t3_a_pass",   32'(if_a.PASS_CNT),   32'd3);
    chk("t3_a_maxulp", if_a.MAX_ULP,         32'h0080_0000);
    chk("t3_b_fidx",   32'(if_b.FAIL_IDX),   32'd4);
    chk("t3_b_fa",     if_b.FAIL_A,          32'h3333_3333);
    chk("t3_b_pass",   32'(if_b.PASS_CNT),   32'd4);
    chk("t3_c_fidx",   32'(if_c.FAIL_IDX),   32'd2);
    clear();

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      send(32'(i), ~32'(i), 32'h3F80_0000, 32'h4000_0000, 1'b0);
    end
    tick(2);
    chk("t4_b_fail", 32'(if_b.FAIL_CNT), 32'd15);
    chk("t4_b_pass", 32'(if_b.PASS_CNT), 32'd0);
    chk("t4_b_fidx", 32'(if_b.FAIL_IDX), 32'd0);
    chk("t4_a_fail", 32'(if_a.FAIL_CNT), 32'd20);
    clear();

    // Termination, overrun and clear
    for (int i = 0; i < 3; i++) begin
      send(32'(i), 32'(i), 32'(i + 1), 32'(i + 1), 1'b0);
    end
    send(32'h5, 32'h5, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    chk("t5_a_done_t",   32'(if_a.DONE), 32'd0);
    tick();
    chk("t5_a_done_t+1", 32'(if_a.DONE), 32'd0);
    tick();
    chk("t5_a_done_t+2", 32'(if_a.DONE),     32'd1);
    chk("t5_a_pass",     32'(if_a.PASS_CNT), 32'd4);
    send(32'h6, 32'h6, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    tick(2);
    chk("t5_a_overrun",  32'(if_a.OVERRUN),  32'd1);
    chk("t5_a_fail_ovr", 32'(if_a.FAIL_CNT), 32'd0);
    chk("t5_a_pass_ovr", 32'(if_a.PASS_CNT), 32'd4);
    chk("t5_b_overrun",  32'(if_b.OVERRUN),  32'd1);
    chk("t5_a_done_ovr", 32'(if_a.DONE),     32'd1);
    clear();
    chk("t5_clr_done",    32'(if_a.DONE),     32'd0);
    chk("t5_clr_overrun", 32'(if_a.OVERRUN),  32'd0);
    chk("t5_clr_pass",    32'(if_a.PASS_CNT), 32'd0);
    clr = 1'b1; valid = 1'b1; o = 32'h3F80_0000; g = 32'h4000_0000;
    tick();
    clr = 1'b0; valid = 1'b0;
    tick(2);
    chk("t5_clrvalid_fail",   32'(if_a.FAIL_CNT),   32'd0);
    chk("t5_clrvalid_fvalid", 32'(if_a.FAIL_VALID), 32'd0);
    send(32'h7, 32'h7, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    tick();
    chk("t5_idle_last_t+1", 32'(if_a.DONE), 32'd0);
    tick();
    chk("t5_idle_last_t+2", 32'(if_a.DONE),     32'd1);
    chk("t5_idle_last_pass", 32'(if_a.PASS_CNT), 32'd1);
    clear();

    // Asynchronous reset with vectors in flight
    send(32'hAA, 32'hBB, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    send(32'hAC, 32'hBD, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    send(32'hAE, 32'hBF, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    chk("t6_pre_fail", 32'(if_a.FAIL_CNT), 32'd1);
    nRST = 1'b0;
    #1;
    chk("t6_rst_fail",   32'(if_a.FAIL_CNT),   32'd0);
    chk("t6_rst_mm",     32'(if_a.MISMATCH),   32'd0);
    chk("t6_rst_fvalid", 32'(if_a.FAIL_VALID), 32'd0);
    chk("t6_rst_maxulp", if_a.MAX_ULP,         32'd0);
    tick();
    nRST = 1'b1;
    tick(2);
    chk("t6_inflight_dropped", 32'(if_a.FAIL_CNT), 32'd0);
    send(32'h5555_5555, 32'h6666_6666, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    tick(2);
    chk("t6_new_fail", 32'(if_a.FAIL_CNT), 32'd1);
    chk("t6_new_fidx", 32'(if_a.FAIL_IDX), 32'd0);
    chk("t6_new_fa",   if_a.FAIL_A,        32'h5555_5555);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_result_checker.md
Name: fpu_result_checker

Overview:
Registered scoreboard directly downstream of the FPU unit under test (add/mul/div/f2i/i2f) in the FPU DUT harness. Each cycle it accepts one vector: operands A and B, the unit output O and the golden value. It classifies each vector as pass or fail, with a configurable ULP tolerance and IEEE-754 special-value rules. It keeps pass/fail counters and the worst ULP error, captures the first failing vector, and raises DONE after the last vector drains, so the harness can end the run on DONE.

Parameters:
ULP_TOL, 0, maximum allowed |ordered(O) - ordered(GOLDEN)| for finite values.
ZERO_EQUIV, 1, 1: +0 and -0 compare equal; 0: zeros must match bit-exactly.
NAN_EQUIV, 1, 1: any NaN matches any NaN; 0: NaNs must match bit-exactly.
CNT_W, 32, width of the vector-index and pass/fail counters.
INT_MODE, 0, 1: exact 32-bit compare only, no float rules (f2i path).

Ports:
MCLK  input  1  clock
nRST  input  1  asynchronous active-low reset
CLR  input  1  synchronous clear of counters, capture and FSM
VALID  input  1  vector present this cycle
LAST  input  1  qualifies VALID; final vector of the run
A  input  32  operand A, for capture only
B  input  32  operand B, for capture only
O  input  32  unit output
GOLDEN  input  32  reference result
MISMATCH  output  1  one-cycle pulse when a failing vector commits
DONE  output  1  high once the run has fully drained
PASS_CNT  output  CNT_W  passing vectors, saturating
FAIL_CNT  output  CNT_W  failing vectors, saturating
MAX_ULP  output  32  largest finite ULP difference seen
FAIL_VALID  output  1  first-fail capture is valid
FAIL_IDX  output  CNT_W  index of the first failing vector
FAIL_A, FAIL_B, FAIL_O, FAIL_GOLDEN  output  32 each  captured first-fail vector
OVERRUN  output  1  sticky: VALID was received while in DONE

Behaviour:
- Reset (nRST low, asynchronous): all outputs 0; FSM enters IDLE; pipeline valid bits cleared. Reset mid-run discards in-flight vectors.
- CLR has the same effect as reset, but synchronous. CLR beats VALID in the same cycle: that vector is dropped and not counted.
- Pipeline:
  - S1 registers the vector and computes the compare.
  - S2 commits the counters, MAX_ULP, capture and MISMATCH.
  - A vector taken at edge t is visible on the outputs after edge t+2. Throughput is 1 vector per cycle; there is no stall.
- Ordered key:
  - key = sign ? 0x8000_0000 - bits[30:0] : 0x8000_0000 + bits[30:0], 32-bit unsigned.
  - diff = |keyO - keyG|.
- Pass rules, in priority order:
  1. INT_MODE: pass iff O == GOLDEN.
  2. Either value NaN: pass iff both are NaN and (NAN_EQUIV or bits equal).
  3. Either value Inf: pass iff bits equal.
  4. Either value zero and ZERO_EQUIV = 0: pass iff bits equal.
  5. Otherwise: pass iff diff <= ULP_TOL.
- MAX_ULP updates only under rule 5; it is max(MAX_ULP, diff), whether the vector passes or fails.
- Counters: the index increments on every accepted vector. PASS_CNT and FAIL_CNT saturate at all-ones and do not wrap. The index also saturates.
- First-fail capture:
  - Loads A, B, O, GOLDEN and the index when a fail commits and FAIL_VALID = 0; FAIL_VALID is then set.
  - It is held until CLR or reset.
- FSM:
  - IDLE -> RUN on VALID.
  - RUN -> DRAIN on VALID & LAST.
  - DRAIN -> DONE once both pipeline stages are empty, i.e. DONE rises 2 cycles after the LAST edge.
  - DONE -> IDLE on CLR only.
  - VALID & LAST in IDLE goes straight to DRAIN.
  - VALID in DRAIN or DONE is dropped and sets OVERRUN.

Decomposition:
- Package fpu_chk_pkg holds:
  - constants F32_QNAN = 32'h7FC0_0000, F32_PINF = 32'h7F80_0000, KEY_BIAS = 32'h8000_0000;
  - enum chk_state_t {IDLE, RUN, DRAIN, DONE};
  - struct chk_vec_t {a, b, o, g};
  - classifier functions is_nan, is_inf, is_zero.
- One sub-module, fpu_ulp_compare: combinational rules 1-5 producing pass and diff. It is instantiated in S1.

Test Plan:
1. Equal and tolerance: O = GOLDEN = 0x3F80_0000 -> PASS_CNT = 1. O = 0x3F80_0001, GOLDEN = 0x3F80_0000: with ULP_TOL = 0 -> FAIL_CNT = 1, MAX_ULP = 1, MISMATCH pulse at edge t+2; with ULP_TOL = 1 -> pass.
2. Specials:
   - 0x7FC0_0000 vs 0x7FC0_0001 passes with NAN_EQUIV = 1 and fails with 0.
   - 0x0000_0000 vs 0x8000_0000 passes with ZERO_EQUIV = 1 and fails with 0.
   - 0x7F80_0000 vs 0x7F7F_FFFF fails with ULP_TOL = 1.
   - 0xBF80_0000 vs 0x3F80_0000 gives diff 0x7F00_0000 and fails.
3. Capture: 5 vectors with fails at indices 2 and 4 -> FAIL_IDX = 2 and FAIL_A/B/O/GOLDEN equal vector 2. FAIL_VALID stays set and vector 4 leaves the capture unchanged.
4. Saturation: CNT_W = 4, 20 failing vectors -> FAIL_CNT = 15, PASS_CNT = 0.
5. Termination: LAST on vector 3 at edge t -> DONE = 1 at edge t+2. A later VALID sets OVERRUN and counters are unchanged. CLR returns all outputs to 0 and the FSM to IDLE.
6. Reset mid-run: deassert nRST with 2 vectors in flight -> all outputs 0 immediately. After release, a new run counts from index 0.
